pickup_ctrl: RTL and testbench

- Operator-stage controller that sits directly upstream of the locker LED/occupancy block and the 8×8 animation screen.
- Collects a 4-digit pickup code from the keypad decoder and matches it against the per-locker code table.
- On a match with an occupied locker, it drives the locker index onto taking and requests the opening animation.
- It also enforces a wrong-attempt lockout and an entry inactivity timeout.

---
 rtl/pickup_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pickup_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pickup_ctrl.sv
`default_nettype none
// ============================================================================
// pickup_ctrl : operator-stage pickup-code matcher with wrong-code lockout
//               and entry inactivity timeout
// Revision    : 1.0
// ============================================================================
module pickup_ctrl #(
  parameter logic [127:0] CODES        = 128'h0007_0006_0005_0004_0003_0002_0001_0000,
  parameter int           MAX_TRIES    = 3,
  parameter int           LOCK_CYCLES  = 20,
  parameter int           IDLE_TIMEOUT = 10,
  parameter int           PLAY_WAIT    = 4
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_val,
  input  logic [7:0]  full,
  input  logic        playing,
  output logic [3:0]  taking,
  output logic        play_start,
  output logic        err,
  output logic        locked,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt
);

  localparam int TMAX_A = (LOCK_CYCLES > IDLE_TIMEOUT) ? LOCK_CYCLES : IDLE_TIMEOUT;
  localparam int TMAX   = (TMAX_A > PLAY_WAIT) ? TMAX_A : PLAY_WAIT;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int NW     = $clog2(MAX_TRIES + 1);
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY     = 3'd1,
    S_CHECK     = 3'd2,
    S_OPEN      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_t;

  state_t          state_q;
  logic [3:0]      taking_q;
  logic            play_start_q;
  logic            err_q;
  logic            locked_q;
  logic [15:0]     entry_q;
  logic [2:0]      digit_cnt_q;
  logic [NW-1:0]   tries_q;
  logic [TW-1:0]   timer_q;

  logic            is_digit;
  logic            hit;
  logic [2:0]      hit_idx;

  assign is_digit = (key_val <= 4'd9);

  // Scan high-to-low so the lowest occupied matching locker wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (entry_q == CODES[16*i +: 16] && full[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // The match result is registered on the enter key, so play_start/err are
  // visible during the single CHECK cycle and CHECK only picks the next state.
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      taking_q     <= 4'hF;
      play_start_q <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
      entry_q      <= 16'h0;
      digit_cnt_q  <= 3'd0;
      tries_q      <= '0;
      timer_q      <= '0;
    end else begin
      play_start_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (key_valid && is_digit) begin
            entry_q     <= {12'h0, key_val};
            digit_cnt_q <= 3'd1;
            state_q     <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (key_valid) begin
            timer_q <= '0;
            if (is_digit) begin
              if (digit_cnt_q != 3'd4) begin
                entry_q     <= {entry_q[11:0], key_val};
                digit_cnt_q <= digit_cnt_q + 3'd1;
              end
            end else if (key_val == KEY_CLR) begin
              entry_q     <= 16'h0;
              digit_cnt_q <= 3'd0;
              state_q     <= S_IDLE;
            end else if (key_val == KEY_ENT) begin
              if (digit_cnt_q == 3'd4) begin
                state_q <= S_CHECK;
                if (hit) begin
                  taking_q     <= {1'b0, hit_idx};
                  play_start_q <= 1'b1;
                  tries_q      <= '0;
                end else begin
                  err_q   <= 1'b1;
                  tries_q <= tries_q + NW'(1);
                end
              end else begin
                entry_q     <= 16'h0;
                digit_cnt_q <= 3'd0;
                err_q       <= 1'b1;
                state_q     <= S_IDLE;
              end
            end
          end else if (timer_q == TW'(IDLE_TIMEOUT - 1)) begin
            timer_q     <= '0;
            entry_q     <= 16'h0;
            digit_cnt_q <= 3'd0;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_CHECK: begin
          timer_q     <= '0;
          entry_q     <= 16'h0;
          digit_cnt_q <= 3'd0;
          if (play_start_q) begin
            state_q <= S_OPEN;
          end else if (tries_q == NW'(MAX_TRIES)) begin
            locked_q <= 1'b1;
            state_q  <= S_LOCKOUT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_OPEN: begin
          if (playing) begin
            timer_q <= '0;
            state_q <= S_WAIT_DONE;
          end else if (timer_q == TW'(PLAY_WAIT - 1)) begin
            timer_q <= '0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!playing) state_q <= S_IDLE;
        end
        S_LOCKOUT: begin
          if (timer_q == TW'(LOCK_CYCLES - 1)) begin
            timer_q  <= '0;
            locked_q <= 1'b0;
            tries_q  <= '0;
            state_q  <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign taking     = taking_q;
  assign play_start = play_start_q;
  assign err        = err_q;
  assign locked     = locked_q;
  assign entry      = entry_q;
  assign digit_cnt  = digit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pickup_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pickup_ctrl : directed self-checking bench for pickup_ctrl
// Revision       : 1.0
// ============================================================================
module tb_pickup_ctrl;

  logic        clk_2 = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_val;
  logic [7:0]  full;
  logic        playing;
  logic [3:0]  taking;
  logic        play_start;
  logic        err;
  logic        locked;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;

  int n_chk = 0;
  int n_err = 0;

  pickup_ctrl dut (
    .clk_2      (clk_2),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_val    (key_val),
    .full       (full),
    .playing    (playing),
    .taking     (taking),
    .play_start (play_start),
    .err        (err),
    .locked     (locked),
    .entry      (entry),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the key is sampled on the following posedge and
  // the task returns at the next negedge.
  task automatic press(input logic [3:0] k);
    key_val   = k;
    key_valid = 1'b1;
    @(negedge clk_2);
    key_valid = 1'b0;
  endtask

  task automatic press_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
  endtask

  initial begin
    int n;
    rst = 1'b0; key_valid = 1'b0; key_val = 4'h0; full = 8'hFF; playing = 1'b0;
    repeat (2) @(negedge clk_2);
    check("rst_taking", 16'(taking), 16'hF);
    check("rst_play", 16'(play_start), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_locked", 16'(locked), 16'h0);
    check("rst_entry", entry, 16'h0);
    check("rst_cnt", 16'(digit_cnt), 16'h0);
    rst = 1'b1;
    @(negedge clk_2);

    // Open locker 3
    press_code(16'h0003);
    check("o3_entry", entry, 16'h0003);
    check("o3_cnt", 16'(digit_cnt), 16'd4);
    press(4'hB);
    check("o3_play", 16'(play_start), 16'h1);
    check("o3_taking", 16'(taking), 16'h3);
    check("o3_noerr", 16'(err), 16'h0);
    @(negedge clk_2);
    check("o3_play_pulse", 16'(play_start), 16'h0);
    @(negedge clk_2);
    playing = 1'b1;
    @(negedge clk_2);
    press(4'h5);
    check("o3_key_ignored", 16'(digit_cnt), 16'd0);
    playing = 1'b0;
    @(negedge clk_2);
    check("o3_taking_hold", 16'(taking), 16'h3);
    press(4'h7);
    check("o3_idle_cnt", 16'(digit_cnt), 16'd1);
    check("o3_idle_entry", entry, 16'h0007);
    press(4'hA);

    // Asynchronous reset mid-entry
    press(4'h1);
    press(4'h2);
    check("ar_entry_pre", entry, 16'h0012);
    #2 rst = 1'b0;
    #1;
    check("ar_taking", 16'(taking), 16'hF);
    check("ar_entry", entry, 16'h0);
    check("ar_cnt", 16'(digit_cnt), 16'd0);
    @(negedge clk_2);
    rst = 1'b1;
    @(negedge clk_2);
    press(4'h5);
    check("ar_idle_entry", entry, 16'h0005);
    check("ar_idle_cnt", 16'(digit_cnt), 16'd1);
    press(4'hA);

    // Occupancy miss counts as wrong try 1; two more misses lock out
    full = 8'hF7;
    press_code(16'h0003);
    press(4'hB);
    check("occ_err", 16'(err), 16'h1);
    check("occ_noplay", 16'(play_start), 16'h0);
    check("occ_taking", 16'(taking), 16'hF);
    @(negedge clk_2);
    check("occ_err_pulse", 16'(err), 16'h0);
    check("occ_cnt_clr", 16'(digit_cnt), 16'd0);
    full = 8'hFF;
    press_code(16'h9999);
    press(4'hB);
    check("lk2_err", 16'(err), 16'h1);
    @(negedge clk_2);
    check("lk2_unlocked", 16'(locked), 16'h0);
    press_code(16'h9999);
    press(4'hB);
    check("lk3_err", 16'(err), 16'h1);
    check("lk3_not_yet", 16'(locked), 16'h0);
    @(negedge clk_2);
    check("lk_locked", 16'(locked), 16'h1);
    press_code(16'h0001);
    press(4'hB);
    check("lk_ign_cnt", 16'(digit_cnt), 16'd0);
    check("lk_ign_play", 16'(play_start), 16'h0);
    check("lk_ign_taking", 16'(taking), 16'hF);
    n = 6;
    while (locked === 1'b1 && n < 40) begin
      @(negedge clk_2);
      n++;
    end
    check("lk_duration", 16'(n - 1), 16'd20);

    // After lockout: open locker 1, screen never starts
    press_code(16'h0001);
    press(4'hB);
    check("o1_play", 16'(play_start), 16'h1);
    check("o1_taking", 16'(taking), 16'h1);
    repeat (4) @(negedge clk_2);
    press(4'h8);
    check("pw_still_open", 16'(digit_cnt), 16'd0);
    press(4'h8);
    check("pw_idle", 16'(digit_cnt), 16'd1);
    check("pw_taking", 16'(taking), 16'h1);
    press(4'hA);

    // Entry edge cases
    press(4'h1); press(4'h2); press(4'hA);
    check("ec_clear_entry", entry, 16'h0);
    check("ec_clear_cnt", 16'(digit_cnt), 16'd0);
    press_code(16'h1234);
    press(4'h5);
    check("ec_5th_entry", entry, 16'h1234);
    check("ec_5th_cnt", 16'(digit_cnt), 16'd4);
    press(4'hA);
    press(4'h1); press(4'h2); press(4'hB);
    check("ec_short_err", 16'(err), 16'h1);
    check("ec_short_cnt", 16'(digit_cnt), 16'd0);
    @(negedge clk_2);
    check("ec_short_pulse", 16'(err), 16'h0);

    // Inactivity timeout and key-beats-expiry
    press(4'h6);
    repeat (9) @(negedge clk_2);
    check("to_pre_cnt", 16'(digit_cnt), 16'd1);
    @(negedge clk_2);
    check("to_cnt", 16'(digit_cnt), 16'd0);
    check("to_entry", entry, 16'h0);
    check("to_noerr", 16'(err), 16'h0);
    press(4'h6);
    repeat (9) @(negedge clk_2);
    press(4'h7);
    check("to_keywin_entry", entry, 16'h0067);
    check("to_keywin_cnt", 16'(digit_cnt), 16'd2);
    press(4'hA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
